// File: rtl/dual_port_pixel_ram_if.sv
// Bus bundle for dual_port_pixel_ram: two independent read/write ports plus the
// post-reset zero-fill status flag.
interface dual_port_pixel_ram_if #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] address_a;
  logic [DATA_WIDTH-1:0] data_a;
  logic                  wren_a;
  logic [DATA_WIDTH-1:0] q_a;
  logic [ADDR_WIDTH-1:0] address_b;
  logic [DATA_WIDTH-1:0] data_b;
  logic                  wren_b;
  logic [DATA_WIDTH-1:0] q_b;
  logic                  init_busy;

  modport master (
    output address_a, data_a, wren_a, address_b, data_b, wren_b,
    input  q_a, q_b, init_busy
  );

  modport slave (
    input  address_a, data_a, wren_a, address_b, data_b, wren_b,
    output q_a, q_b, init_busy
  );
endinterface

// File: rtl/dual_port_pixel_ram.sv
// True dual-port RGB pixel RAM with a post-reset zero-fill sweep.
// Define RAM_OUT_REG_EN to add a second output register stage (2-cycle read latency).
module dual_port_pixel_ram #(
  parameter int unsigned DATA_WIDTH = 24,
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DEPTH      = 4428
) (
  input logic                 game_clk,
  input logic                 reset,
  dual_port_pixel_ram_if.slave ram
);

  localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] DepthLim = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DEPTH - 1);

  localparam logic [0:0] StClear = 1'b0;
  localparam logic [0:0] StRun   = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [IdxW-1:0]       clear_ptr_q, clear_ptr_d;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  in_a, in_b;
  logic [IdxW-1:0]       idx_a, idx_b;
  logic                  clearing, running, collide;
  logic                  wa_en, wb_en;
  logic [IdxW-1:0]       wa_idx;
  logic [DATA_WIDTH-1:0] wa_data;
  logic [DATA_WIDTH-1:0] rd_a_q, rd_b_q;

  assign in_a  = {1'b0, ram.address_a} < DepthLim;
  assign in_b  = {1'b0, ram.address_b} < DepthLim;
  assign idx_a = ram.address_a[IdxW-1:0];
  assign idx_b = ram.address_b[IdxW-1:0];

  assign clearing = (state_q == StClear) && !reset;
  assign running  = (state_q == StRun) && !reset;

  // Loader port owns the word when both ports write the same address.
  assign collide = ram.wren_b && in_b && (idx_a == idx_b);

  // The sweep borrows port A's write path; user writes are locked out meanwhile.
  assign wa_en   = clearing || (running && ram.wren_a && in_a && !collide);
  assign wa_idx  = clearing ? clear_ptr_q : idx_a;
  assign wa_data = clearing ? '0 : ram.data_a;
  assign wb_en   = running && ram.wren_b && in_b;

  always_comb begin
    state_d     = state_q;
    clear_ptr_d = clear_ptr_q;
    if (state_q == StClear) begin
      clear_ptr_d = clear_ptr_q + 1'b1;
      if (clear_ptr_q == LastIdx) begin
        state_d     = StRun;
        clear_ptr_d = '0;
      end
    end
  end

  always_ff @(posedge game_clk) begin
    if (reset) begin
      state_q     <= StClear;
      clear_ptr_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_ptr_q <= clear_ptr_d;
    end
  end

  // Storage is left unreset so it maps onto block RAM.
  always_ff @(posedge game_clk) begin
    if (wa_en) mem[wa_idx] <= wa_data;
    if (wb_en) mem[idx_b] <= ram.data_b;
  end

  always_ff @(posedge game_clk) begin
    if (reset || state_q != StRun) begin
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      rd_a_q <= in_a ? mem[idx_a] : '0;
      rd_b_q <= in_b ? mem[idx_b] : '0;
    end
  end

`ifdef RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] out_a_q, out_b_q;

  always_ff @(posedge game_clk) begin
    if (reset) begin
      out_a_q <= '0;
      out_b_q <= '0;
    end else begin
      out_a_q <= rd_a_q;
      out_b_q <= rd_b_q;
    end
  end

  assign ram.q_a = out_a_q;
  assign ram.q_b = out_b_q;
`else
  assign ram.q_a = rd_a_q;
  assign ram.q_b = rd_b_q;
`endif

  assign ram.init_busy = (state_q == StClear);

endmodule

// File: tb/tb_dual_port_pixel_ram.sv
// Self-checking bench for dual_port_pixel_ram (DEPTH=16, ADDR_WIDTH=5) against a
// behavioural memory model.
module tb_dual_port_pixel_ram;
  localparam int DW    = 24;
  localparam int AW    = 5;
  localparam int DEPTH = 16;
`ifdef RAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dual_port_pixel_ram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  dual_port_pixel_ram #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .DEPTH     (DEPTH)
  ) dut (
    .game_clk(clk),
    .reset   (rst),
    .ram     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference state: memory contents, cycles of zero-fill left, read pipeline.
  logic [DW-1:0] mem_m [DEPTH];
  int            clear_left = DEPTH;
  logic [DW-1:0] s1a = '0, s2a = '0, s1b = '0, s2b = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    if (clear_left > 0 || a >= DEPTH) return '0;
    return mem_m[a[3:0]];
  endfunction

  // One clock: predict, step the model at the edge, then compare all outputs.
  task automatic tick();
    logic [DW-1:0] ra, rb;
    logic          busy_before;
    busy_before = clear_left > 0;
    ra = model_rd(bus.address_a);
    rb = model_rd(bus.address_b);
    @(posedge clk);
    if (rst) begin
      clear_left = DEPTH;
      foreach (mem_m[i]) mem_m[i] = '0;
      s1a = '0; s2a = '0; s1b = '0; s2b = '0;
    end else begin
      s2a = s1a;
      s2b = s1b;
      if (busy_before) begin
        clear_left--;
        s1a = '0;
        s1b = '0;
      end else begin
        s1a = ra;
        s1b = rb;
        if (bus.wren_a && bus.address_a < DEPTH &&
            !(bus.wren_b && bus.address_b == bus.address_a))
          mem_m[bus.address_a[3:0]] = bus.data_a;
        if (bus.wren_b && bus.address_b < DEPTH)
          mem_m[bus.address_b[3:0]] = bus.data_b;
      end
    end
    #1;
    check("q_a", bus.q_a, (LAT == 1) ? s1a : s2a);
    check("q_b", bus.q_b, (LAT == 1) ? s1b : s2b);
    check("init_busy", bus.init_busy, clear_left > 0);
  endtask

  task automatic idle();
    bus.wren_a = 1'b0;
    bus.wren_b = 1'b0;
  endtask

  // Counts busy samples from the reset edge onward; reset must already be released.
  task automatic measure_clear(input string tag);
    int n;
    n = bus.init_busy ? 1 : 0;
    for (int i = 0; i < 40 && bus.init_busy; i++) begin
      tick();
      if (bus.init_busy) n++;
    end
    check(tag, n, DEPTH);
    check("busy_fell", bus.init_busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.address_a = '0; bus.data_a = '0; bus.wren_a = 1'b0;
    bus.address_b = '0; bus.data_b = '0; bus.wren_b = 1'b0;

    // Single-cycle reset pulse, then the sweep.
    rst = 1'b1;
    tick();
    check("rst_busy", bus.init_busy, 1'b1);
    rst = 1'b0;
    measure_clear("clear_len");

    // Whole array reads back zero.
    for (int i = 0; i < DEPTH + LAT - 1; i++) begin
      bus.address_a = (i < DEPTH) ? AW'(i) : '0;
      tick();
      if (i >= LAT - 1) check("zero_fill", bus.q_a, 0);
    end

    // Basic loader write then video read.
    bus.address_b = 5; bus.data_b = 24'hFF00FF; bus.wren_b = 1'b1;
    tick();
    idle();
    bus.address_a = 5;
    tick();
    repeat (LAT - 1) tick();
    check("basic_rd", bus.q_a, 24'hFF00FF);

    // Same-port read-before-write.
    bus.address_b = 3; bus.data_b = 24'h123456; bus.wren_b = 1'b1;
    tick();
    idle();
    bus.address_a = 3; bus.data_a = 24'hABCDEF; bus.wren_a = 1'b1;
    tick();
    bus.wren_a = 1'b0;
    repeat (LAT - 1) tick();
    check("rbw_old", bus.q_a, 24'h123456);
    tick();
    check("rbw_new", bus.q_a, 24'hABCDEF);

    // Mixed-port: A reads the word B is writing.
    bus.address_a = 5; bus.address_b = 5; bus.data_b = 24'h0000AA; bus.wren_b = 1'b1;
    tick();
    idle();
    repeat (LAT - 1) tick();
    check("mixed_old", bus.q_a, 24'hFF00FF);

    // Same-address collision: B wins.
    bus.address_a = 7; bus.data_a = 24'h111111; bus.wren_a = 1'b1;
    bus.address_b = 7; bus.data_b = 24'h222222; bus.wren_b = 1'b1;
    tick();
    idle();
    tick();
    repeat (LAT - 1) tick();
    check("collide_a", bus.q_a, 24'h222222);
    check("collide_b", bus.q_b, 24'h222222);

    // Out-of-range write must not alias onto address 4.
    bus.address_b = 20; bus.data_b = 24'hFFFFFF; bus.wren_b = 1'b1;
    tick();
    idle();
    bus.address_a = 20; bus.address_b = 4;
    tick();
    repeat (LAT - 1) tick();
    check("oor_rd", bus.q_a, 0);
    check("oor_alias", bus.q_b, 0);

    // Randomized traffic, including out-of-range and forced collisions.
    for (int i = 0; i < 400; i++) begin
      bus.address_a = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(16, 31))
                                                  : AW'($urandom_range(0, 15));
      bus.address_b = ($urandom_range(0, 3) == 0) ? AW'($urandom_range(16, 31))
                                                  : AW'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) bus.address_b = bus.address_a;
      bus.data_a = DW'($urandom);
      bus.data_b = DW'($urandom);
      bus.wren_a = 1'($urandom_range(0, 1));
      bus.wren_b = 1'($urandom_range(0, 1));
      tick();
    end
    idle();

    // Reset in the middle of the sweep; writes during the sweep must be dropped.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.address_a = 9; bus.data_a = 24'h555555; bus.wren_a = 1'b1;
    repeat (8) tick();
    rst = 1'b1;
    tick();
    check("mid_busy", bus.init_busy, 1'b1);
    check("mid_q_a", bus.q_a, 0);
    check("mid_q_b", bus.q_b, 0);
    rst = 1'b0;
    measure_clear("reclear_len");
    bus.wren_a = 1'b0;
    bus.address_a = 9; bus.address_b = 7;
    tick();
    repeat (LAT - 1) tick();
    check("post_clear_a", bus.q_a, 0);
    check("post_clear_b", bus.q_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/dual_port_pixel_ram.md
Name: dual_port_pixel_ram

Overview:
Synchronous true dual-port pixel RAM holding 24-bit RGB words (0xRRGGBB). One instance stores the sprite/element bitmap and another stores the full-screen backgrounds. Port A is the video-side lookup port. Port B is the loader port that copies image data in from SDRAM during initialisation. Both ports run on one clock. After reset the block performs a zero-fill sweep, and signals it with init_busy.

Parameters:
DATA_WIDTH, 24, word width (RGB888).
ADDR_WIDTH, 16, width of address_a/address_b.
DEPTH, 4428, number of words. Valid addresses are 0..DEPTH-1; must satisfy DEPTH <= 2**ADDR_WIDTH. The screen instance uses DEPTH=86400, ADDR_WIDTH=17.

Ports:
game_clk  in  1  sole clock; all logic on rising edge
reset  in  1  synchronous, active-high
address_a  in  ADDR_WIDTH  port A word address
data_a  in  DATA_WIDTH  port A write data
wren_a  in  1  port A write enable
q_a  out  DATA_WIDTH  port A registered read data
address_b  in  ADDR_WIDTH  port B word address
data_b  in  DATA_WIDTH  port B write data
wren_b  in  1  port B write enable
q_b  out  DATA_WIDTH  port B registered read data
init_busy  out  1  high while post-reset zero-fill runs

Behaviour:
- Clocking and reset: one clock domain. Reset is synchronous and active-high.
- Reset values: q_a=0, q_b=0, init_busy=1 on the first edge after reset asserts. A reset assertion mid-sweep restarts the sweep at address 0.
- State machine CLEAR: clear_ptr walks 0..DEPTH-1, writing 0 at one word per cycle.
  - During CLEAR, port A/B writes are ignored and q_a/q_b hold 0.
  - On the cycle clear_ptr==DEPTH-1 is written, go to RUN; init_busy falls on the next edge.
  - CLEAR therefore takes exactly DEPTH cycles after reset deasserts.
- State machine RUN: normal dual-port operation. There are no other states.
- Read latency: 1 cycle. q_x on edge N+1 reflects address_x sampled at edge N.
- Write: wren_x=1 at edge N stores data_x at address_x. The word is visible to reads issued at edge N+1 or later.
- Same-port read-during-write: q_x returns the OLD word (read-before-write).
- Mixed-port read-during-write (A reads the address B writes, or vice versa): the reader gets the OLD word.
- Simultaneous writes to the same address on both ports: port B wins (loader has priority), and port A's write is discarded.
- Out-of-range address (>= DEPTH):
  - writes are ignored with no aliasing or wrap;
  - reads return 0 on the next cycle.
- Data is stored verbatim. No width conversion is done inside the block; any SDRAM 16-bit-to-24-bit packing is done by the caller.
- When reset is held high, no writes occur and outputs stay 0.
- The storage array must be inferable as block RAM. Only the output registers and the state/pointer registers are reset.

Optional Feature:
Macro RAM_OUT_REG_EN.
- When defined: adds a second registered stage on q_a and q_b. Read latency becomes 2 cycles, and both stages reset to 0.
- Read-during-write and collision semantics are unchanged, just delayed one cycle.
- When undefined: read latency is 1 cycle, as above.

Test Plan:
- Clear sweep: DEPTH=16. Pulse reset for 1 cycle. Required response: init_busy stays high for exactly 16 cycles and then falls. Reading all 16 addresses on port A then returns 0x000000.
- Basic write/read: after init, B writes 0xFF00FF at address 5. Port A reads address 5 on the next cycle. Required response: q_a=0xFF00FF exactly 1 cycle after the read address is presented (2 cycles with RAM_OUT_REG_EN).
- Read-before-write: address 3 holds 0x123456. Port A writes 0xABCDEF to address 3 while also reading it. Required response: q_a=0x123456; the next read returns 0xABCDEF.
- Collision: A writes 0x111111 and B writes 0x222222 to address 7 in the same cycle. Required response: a subsequent read on either port returns 0x222222.
- Out of range: DEPTH=16, ADDR_WIDTH=5. B writes 0xFFFFFF to address 20. Required response: reading address 20 returns 0, and address 4 is unchanged (0).
- Reset mid-operation: assert reset while clear_ptr=8. Required response: q_a=q_b=0 and init_busy=1; after release the sweep restarts and takes the full DEPTH cycles again.
